// File: rtl/sb_pkg.sv
// Shared types for the system-bus peripheral arbiter: request bundle and lock FSM states.
package sb_pkg;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic                 we;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] wdata;
  } sb_req_t;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } sb_arb_state_e;
endpackage

// File: rtl/sb_periph_arbiter_rr_picker.sv
// Combinational round-robin picker: first masked requester at or above ptr_i, wrapping.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);
  logic          found;
  logic [IW-1:0] j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = IW'((int'(ptr_i) + i) % N);
      if (!found && req_i[j] && mask_i[j]) begin
        found    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end
endmodule

// File: rtl/sb_periph_arbiter.sv
// Round-robin arbiter with bounded bus lock sharing one peripheral port; routes one-cycle read data
// back to the issuing master. Valid/ready: an access is accepted exactly in the cycle m_gnt_o[k] is high.
module sb_periph_arbiter
  import sb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int LOCK_MAX    = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NUM_MASTERS-1:0]                 m_req_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS-1:0]                 m_lock_i,
  input  logic [NUM_MASTERS-1:0][SB_ADDR_W-1:0]  m_addr_i,
  input  logic [NUM_MASTERS-1:0][SB_DATA_W-1:0]  m_wdata_i,
  output logic [NUM_MASTERS-1:0]                 m_gnt_o,
  output logic [NUM_MASTERS-1:0]                 m_rvalid_o,
  output logic [NUM_MASTERS-1:0][SB_DATA_W-1:0]  m_rdata_o,
  output logic                                   s_req_o,
  output logic                                   s_we_o,
  output logic [SB_ADDR_W-1:0]                   s_addr_o,
  output logic [SB_DATA_W-1:0]                   s_wdata_o,
  input  logic [SB_DATA_W-1:0]                   s_rdata_i,
  output sb_arb_state_e                          dbg_state_o
);
  localparam int         IW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  sb_arb_state_e    state_q;
  logic [IW-1:0]    rr_ptr_q, owner_q, excl_idx_q, rd_owner_q;
  logic [7:0]       lock_cnt_q;
  logic             excl_vld_q, rd_pend_q;

  logic [NUM_MASTERS-1:0] excl_oh, arb_mask, pick_gnt, gnt;
  logic [IW-1:0]          pick_idx, gnt_idx, ptr_nxt;
  logic [7:0]             cnt_nxt;
  logic                   gnt_any, gnt_rd;
  sb_req_t                s_sel;

  // A force-released owner is skipped for one cycle, but only if someone else wants the bus.
  always_comb begin
    excl_oh = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (excl_vld_q && (excl_idx_q == IW'(i))) excl_oh[i] = 1'b1;
    end
    arb_mask = (|(m_req_i & ~excl_oh)) ? ~excl_oh : '1;
  end

  rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_picker (
    .req_i  (m_req_i),
    .ptr_i  (rr_ptr_q),
    .mask_i (arb_mask),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = pick_idx;
    if (!rst_ni) begin
      gnt = '0;
    end else if (state_q == LOCKED) begin
      gnt_idx = owner_q;
      if (m_req_i[owner_q]) gnt[owner_q] = 1'b1;
    end else begin
      gnt = pick_gnt;
    end
  end

  assign gnt_any = |gnt;
  assign gnt_rd  = gnt_any && !m_we_i[gnt_idx];
  assign ptr_nxt = (gnt_idx == IW'(NUM_MASTERS - 1)) ? '0 : gnt_idx + IW'(1);
  assign cnt_nxt = lock_cnt_q + {7'd0, gnt_any};
  assign m_gnt_o = gnt;

  always_comb begin
    s_sel = '0;
    if (gnt_any) begin
      s_sel.we    = m_we_i[gnt_idx];
      s_sel.addr  = m_addr_i[gnt_idx];
      s_sel.wdata = m_wdata_i[gnt_idx];
    end
  end

  assign s_req_o     = gnt_any;
  assign s_we_o      = s_sel.we;
  assign s_addr_o    = s_sel.addr;
  assign s_wdata_o   = s_sel.wdata;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      excl_vld_q <= 1'b0;
      excl_idx_q <= '0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= '0;
    end else begin
      excl_vld_q <= 1'b0;
      rd_pend_q  <= gnt_rd;
      if (gnt_rd)  rd_owner_q <= gnt_idx;
      if (gnt_any) rr_ptr_q   <= ptr_nxt;
      case (state_q)
        ARB: begin
          if (gnt_any && m_lock_i[gnt_idx]) begin
            if (LOCK_MAX <= 1) begin
              excl_vld_q <= 1'b1;
              excl_idx_q <= gnt_idx;
            end else begin
              state_q    <= LOCKED;
              owner_q    <= gnt_idx;
              lock_cnt_q <= 8'd1;
            end
          end
        end
        LOCKED: begin
          if (gnt_any) lock_cnt_q <= cnt_nxt;
          if (!m_lock_i[owner_q]) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
          end else if (cnt_nxt == LOCK_MAX_C) begin
            state_q    <= ARB;
            lock_cnt_q <= '0;
            excl_vld_q <= 1'b1;
            excl_idx_q <= owner_q;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rd_pend_q && (rd_owner_q == IW'(i))) begin
        m_rvalid_o[i] = 1'b1;
        m_rdata_o[i]  = s_rdata_i;
      end
    end
  end
endmodule

// File: tb/tb_sb_periph_arbiter.sv
// Bench for sb_periph_arbiter: vector table, directed lock/read/reset sequences, random traffic vs model.
module tb_sb_periph_arbiter;
  import sb_pkg::*;

  localparam int NM = 2;
  localparam int LM = 8;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NM-1:0]        req_r, we_r, lock_r;
  logic [NM-1:0][31:0]  addr_r, wdata_r;
  logic [NM-1:0]        m_gnt_o, m_rvalid_o;
  logic [NM-1:0][31:0]  m_rdata_o;
  logic                 s_req_o, s_we_o;
  logic [31:0]          s_addr_o, s_wdata_o;
  logic [31:0]          s_rdata = 32'h0;
  sb_arb_state_e        dbg_state;

  int total = 0;
  int bad   = 0;

  sb_periph_arbiter #(.NUM_MASTERS(NM), .LOCK_MAX(LM)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(req_r), .m_we_i(we_r), .m_lock_i(lock_r),
    .m_addr_i(addr_r), .m_wdata_i(wdata_r),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata), .dbg_state_o(dbg_state)
  );

  always #5 clk_i = ~clk_i;

  // Slave: val register at 0x0, mode register at 0x4, registered read data.
  logic [31:0] sl_reg0 = 32'h0000_00A5;
  logic [31:0] sl_reg1 = 32'h0000_003C;
  always @(posedge clk_i) begin
    if (s_req_o) begin
      if (s_we_o) begin
        if (s_addr_o == 32'h0) sl_reg0 <= s_wdata_o;
        else if (s_addr_o == 32'h4) sl_reg1 <= s_wdata_o;
      end else begin
        s_rdata <= (s_addr_o == 32'h0) ? sl_reg0 : (s_addr_o == 32'h4) ? sl_reg1 : 32'h0;
      end
    end
  end

  // Reference model: who owns the bus, how many locked grants, which master sits out a cycle.
  int          mdl_ptr, mdl_owner, mdl_cnt, mdl_excl, cur_g;
  logic [31:0] mdl_reg[2];
  logic [32:0] exp_q[$];

  task automatic model_reset();
    mdl_ptr = 0; mdl_owner = -1; mdl_cnt = 0; mdl_excl = -1;
    exp_q.delete();
  endtask

  function automatic int mdl_pick();
    bit others;
    if (mdl_owner >= 0) return req_r[mdl_owner] ? mdl_owner : -1;
    others = 1'b0;
    for (int i = 0; i < NM; i++) if (req_r[i] && i != mdl_excl) others = 1'b1;
    for (int i = 0; i < NM; i++) begin
      int c;
      c = (mdl_ptr + i) % NM;
      if (req_r[c] && !(others && c == mdl_excl)) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_phase();
    logic [NM-1:0]       eg, erv;
    logic [NM-1:0][31:0] erd;
    logic [32:0]         e;
    int                  g;
    @(negedge clk_i);
    g  = mdl_pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", m_gnt_o, eg);
    chk("s_req", s_req_o, g >= 0);
    chk("s_we", s_we_o, (g >= 0) ? we_r[g] : 1'b0);
    chk("s_addr", s_addr_o, (g >= 0) ? addr_r[g] : 32'h0);
    chk("s_wdata", s_wdata_o, (g >= 0) ? wdata_r[g] : 32'h0);
    erv = '0; erd = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      erv[e[32]] = 1'b1;
      erd[e[32]] = e[31:0];
    end
    chk("rvalid", m_rvalid_o, erv);
    chk("rdata", m_rdata_o, erd);
    chk("state", dbg_state == LOCKED, mdl_owner >= 0);
    cur_g = g;
  endtask

  task automatic advance_phase();
    int g, new_excl;
    @(posedge clk_i);
    g = cur_g;
    if (g >= 0) begin
      mdl_ptr = (g + 1) % NM;
      if (!we_r[g]) begin
        exp_q.push_back({1'(g), (addr_r[g] == 32'h0) ? mdl_reg[0] :
                                (addr_r[g] == 32'h4) ? mdl_reg[1] : 32'h0});
      end else if (addr_r[g] == 32'h0) mdl_reg[0] = wdata_r[g];
      else if (addr_r[g] == 32'h4) mdl_reg[1] = wdata_r[g];
    end
    new_excl = -1;
    if (mdl_owner >= 0) begin
      if (g == mdl_owner) mdl_cnt++;
      if (!lock_r[mdl_owner]) mdl_owner = -1;
      else if (mdl_cnt == LM) begin new_excl = mdl_owner; mdl_owner = -1; end
    end else if (g >= 0 && lock_r[g]) begin
      mdl_cnt = 1;
      if (LM == 1) new_excl = g; else mdl_owner = g;
    end
    mdl_excl = new_excl;
    #1;
  endtask

  task automatic tick();
    check_phase();
    advance_phase();
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] w, input logic [1:0] lk,
                       input logic [31:0] a0, input logic [31:0] a1);
    req_r = rq; we_r = w; lock_r = lk; addr_r[0] = a0; addr_r[1] = a1;
  endtask

  typedef struct {
    logic [1:0]  req, we, lock;
    logic [31:0] a0, a1;
    logic [1:0]  gnt, rv;
    logic [31:0] rd0, rd1, saddr;
  } vec_t;
  vec_t vt[11];

  initial begin
    mdl_reg[0] = 32'h0000_00A5;
    mdl_reg[1] = 32'h0000_003C;
    vt[0] = '{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b00, 32'h0,  32'h0, 32'h0};
    vt[1] = '{2'b01, 2'b00, 2'b00, 32'h0,   32'h0,   2'b01, 2'b00, 32'h0,  32'h0, 32'h0};
    vt[2] = '{2'b00, 2'b00, 2'b00, 32'h0,   32'h0,   2'b00, 2'b01, 32'hA5, 32'h0, 32'h0};
    for (int i = 3; i < 11; i++)
      vt[i] = '{2'b11, 2'b11, 2'b00, 32'h100, 32'h200, (i % 2) ? 2'b10 : 2'b01, 2'b00,
                32'h0, 32'h0, (i % 2) ? 32'h200 : 32'h100};

    rst_ni = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    wdata_r[0] = 32'h1111_0000; wdata_r[1] = 32'h2222_0000;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_gnt", m_gnt_o, 2'b00);
    chk("rst_rvalid", m_rvalid_o, 2'b00);
    chk("rst_rdata", m_rdata_o, 64'h0);
    chk("rst_s", {s_req_o, s_we_o, s_addr_o, s_wdata_o}, 64'h0);
    rst_ni = 1'b1;

    // Vector table: idle, single read and its return, then unlocked alternation.
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].req, vt[i].we, vt[i].lock, vt[i].a0, vt[i].a1);
      check_phase();
      chk("tab_gnt", m_gnt_o, vt[i].gnt);
      chk("tab_rvalid", m_rvalid_o, vt[i].rv);
      chk("tab_rdata", m_rdata_o, {vt[i].rd1, vt[i].rd0});
      chk("tab_saddr", s_addr_o, vt[i].saddr);
      advance_phase();
    end

    // Locked write stream from m1 bounded at LM grants, then m0, then alternation.
    drive(2'b11, 2'b11, 2'b10, 32'h100, 32'h300);
    for (int i = 0; i < LM; i++) begin
      check_phase(); chk("lock_run", m_gnt_o, 2'b10); advance_phase();
    end
    lock_r = 2'b00;
    check_phase(); chk("forced_rel", m_gnt_o, 2'b01); advance_phase();
    check_phase(); chk("alt_a", m_gnt_o, 2'b10); advance_phase();
    check_phase(); chk("alt_b", m_gnt_o, 2'b01); advance_phase();

    // Locked owner idles with lock held: bus stays idle until lock drops.
    drive(2'b10, 2'b11, 2'b10, 32'h100, 32'h300);
    check_phase(); chk("lk_take", m_gnt_o, 2'b10); advance_phase();
    drive(2'b01, 2'b11, 2'b10, 32'h100, 32'h300);
    check_phase(); chk("lk_idle0", m_gnt_o, 2'b00); advance_phase();
    check_phase(); chk("lk_idle1", m_gnt_o, 2'b00); advance_phase();
    lock_r = 2'b00;
    check_phase(); chk("lk_drop", m_gnt_o, 2'b00); advance_phase();
    check_phase(); chk("lk_after", m_gnt_o, 2'b01); advance_phase();

    // Pipelined reads from both masters, no cross-delivery.
    drive(2'b01, 2'b00, 2'b00, 32'h4, 32'h0);
    check_phase(); chk("rd_g0", m_gnt_o, 2'b01); advance_phase();
    drive(2'b10, 2'b00, 2'b00, 32'h4, 32'h0);
    check_phase(); chk("rd_g1", m_gnt_o, 2'b10);
    chk("rd_rv0", m_rvalid_o, 2'b01); chk("rd_d0", m_rdata_o, {32'h0, 32'h3C}); advance_phase();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    check_phase(); chk("rd_rv1", m_rvalid_o, 2'b10);
    chk("rd_d1", m_rdata_o, {32'hA5, 32'h0}); advance_phase();

    // Reset right after a granted read.
    drive(2'b01, 2'b00, 2'b00, 32'h0, 32'h0);
    tick();
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_rv", m_rvalid_o, 2'b00);
    chk("mid_rst_gnt", m_gnt_o, 2'b00);
    chk("mid_rst_sreq", s_req_o, 1'b0);
    chk("mid_rst_rd", m_rdata_o, 64'h0);
    model_reset();
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();
    drive(2'b11, 2'b11, 2'b00, 32'h100, 32'h200);
    check_phase(); chk("ptr_restart", m_gnt_o, 2'b01); advance_phase();

    // Random traffic; a request is held unchanged until granted.
    drive(2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
    for (int n = 0; n < 400; n++) begin
      for (int m = 0; m < NM; m++) begin
        if (!(req_r[m] && cur_g != m && n > 0)) begin
          req_r[m]   = 1'($urandom_range(0, 1));
          we_r[m]    = 1'($urandom_range(0, 1));
          lock_r[m]  = ($urandom_range(0, 3) == 0);
          addr_r[m]  = (32'($urandom_range(0, 2)) * 32'h4);
          wdata_r[m] = $urandom;
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
